// File: rtl/sound_pkg.sv
// Definitions shared by the sound channel controllers: register map, noise timer and LFSR
// helpers, and the frame-sequencer step assignments.
package sound_pkg;

    localparam logic [1:0] AddrNr41 = 2'd0;
    localparam logic [1:0] AddrNr42 = 2'd1;
    localparam logic [1:0] AddrNr43 = 2'd2;
    localparam logic [1:0] AddrNr44 = 2'd3;

    localparam int unsigned LfsrWidth  = 15;
    localparam int unsigned TimerWidth = 20;
    localparam logic [LfsrWidth-1:0] LfsrSeed = 15'h7FFF;

    // Shifts above this value stop the noise clock entirely.
    localparam logic [3:0] MaxClockedShift = 4'd13;

    localparam logic [2:0] EnvelopeStep = 3'd7;
    localparam logic [6:0] FullLength   = 7'd64;

    typedef enum logic {
        StIdle,
        StRun
    } noiseState_t;

    function automatic logic [TimerWidth-1:0] divisor(input logic [2:0] code);
        if (code == 3'd0) begin
            return 20'd8;
        end
        return {13'd0, code, 4'd0};
    endfunction

    function automatic logic [TimerWidth-1:0] timerPeriod(input logic [2:0] code,
                                                          input logic [3:0] shift);
        return divisor(code) << shift;
    endfunction

    function automatic logic [LfsrWidth-1:0] lfsrShift(input logic [LfsrWidth-1:0] value,
                                                       input logic narrow);
        logic                 feedback;
        logic [LfsrWidth-1:0] shifted;
        feedback = value[0] ^ value[1];
        shifted  = {feedback, value[LfsrWidth-1:1]};
        if (narrow) begin
            shifted[6] = feedback;
        end
        return shifted;
    endfunction

    // Length is clocked on the even steps 0, 2, 4 and 6.
    function automatic logic isLengthStep(input logic [2:0] step);
        return !step[0];
    endfunction

endpackage

// File: rtl/sound_frame_sequencer.sv
// Frame sequencer: divides the system clock down to frame ticks and walks a 3-bit step,
// emitting one-cycle length and envelope tick pulses.
module sound_frame_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned FRAME_DIV = 8192
) (
    input  logic iClock,
    input  logic iReset,
    output logic oLengthTick,
    output logic oEnvelopeTick
);

    localparam int unsigned CountWidth = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(FRAME_DIV - 1);

    logic [CountWidth-1:0] frameCount;
    logic [2:0]            step;
    logic                  tick;

    assign tick = (frameCount == LastCount);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            frameCount <= '0;
            step       <= '0;
        end else if (tick) begin
            frameCount <= '0;
            step       <= step + 3'd1;
        end else begin
            frameCount <= frameCount + CountWidth'(1);
        end
    end

    // The pulse carries the step being completed; the step advances afterwards.
    assign oLengthTick   = tick && isLengthStep(step);
    assign oEnvelopeTick = tick && (step == EnvelopeStep);

endmodule

// File: rtl/noise_channel_controller.sv
// Channel-4 noise controller: decodes NR41-NR44, runs the frequency timer that clocks the
// LFSR, and applies length and envelope to produce the registered sample and enable flag.
module noise_channel_controller
    import sound_pkg::*;
#(
    parameter int unsigned FRAME_DIV = 8192
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iWriteEnable,
    input  logic [1:0] iAddress,
    input  logic [7:0] iData,
    output logic [3:0] oSample,
    output logic       oEnabled
);

    noiseState_t           state;
    logic [7:0]            nr42;
    logic [7:0]            nr43;
    logic                  lengthEnable;
    logic [6:0]            lengthCount;
    logic [3:0]            volume;
    logic [2:0]            envelopeCount;
    logic [TimerWidth-1:0] timerCount;
    logic [LfsrWidth-1:0]  lfsr;

    logic lengthTick;
    logic envelopeTick;

    sound_frame_sequencer #(
        .FRAME_DIV(FRAME_DIV)
    ) frameSequencer (
        .iClock       (iClock),
        .iReset       (iReset),
        .oLengthTick  (lengthTick),
        .oEnvelopeTick(envelopeTick)
    );

    logic                  wrNr41;
    logic                  wrNr42;
    logic                  wrNr43;
    logic                  wrNr44;
    logic                  trigger;
    logic                  dacOn;
    logic                  dacOffWrite;
    logic                  lengthExpire;
    logic                  timerActive;
    logic [TimerWidth-1:0] period;
    logic [2:0]            envelopePeriod;
    logic [3:0]            volumeStepped;

    assign wrNr41  = iWriteEnable && (iAddress == AddrNr41);
    assign wrNr42  = iWriteEnable && (iAddress == AddrNr42);
    assign wrNr43  = iWriteEnable && (iAddress == AddrNr43);
    assign wrNr44  = iWriteEnable && (iAddress == AddrNr44);
    assign trigger = wrNr44 && iData[7];

    assign dacOn          = (nr42[7:3] != 5'd0);
    assign dacOffWrite    = wrNr42 && (iData[7:3] == 5'd0);
    assign envelopePeriod = nr42[2:0];
    assign period         = timerPeriod(nr43[2:0], nr43[7:4]);
    assign timerActive    = (state == StRun) && (nr43[7:4] <= MaxClockedShift);

    // A trigger or NR41 write in the same cycle swallows the length tick.
    assign lengthExpire = lengthTick && lengthEnable && (lengthCount == 7'd1)
                          && !trigger && !wrNr41;

    always_comb begin
        volumeStepped = volume;
        if (nr42[3] && (volume != 4'hF)) begin
            volumeStepped = volume + 4'd1;
        end else if (!nr42[3] && (volume != 4'h0)) begin
            volumeStepped = volume - 4'd1;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            nr42         <= '0;
            nr43         <= '0;
            lengthEnable <= 1'b0;
        end else begin
            if (wrNr42) begin
                nr42 <= iData;
            end
            if (wrNr43) begin
                nr43 <= iData;
            end
            if (wrNr44) begin
                lengthEnable <= iData[6];
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            lengthCount <= '0;
        end else if (wrNr41) begin
            lengthCount <= FullLength - {1'b0, iData[5:0]};
        end else if (trigger) begin
            if (lengthCount == 7'd0) begin
                lengthCount <= FullLength;
            end
        end else if (lengthTick && lengthEnable && (lengthCount != 7'd0)) begin
            lengthCount <= lengthCount - 7'd1;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            volume        <= '0;
            envelopeCount <= '0;
        end else if (trigger) begin
            volume        <= nr42[7:4];
            envelopeCount <= envelopePeriod;
        end else if (envelopeTick && (envelopePeriod != 3'd0)) begin
            // A zero count (period set after trigger) is treated as an expiry.
            if (envelopeCount <= 3'd1) begin
                envelopeCount <= envelopePeriod;
                volume        <= volumeStepped;
            end else begin
                envelopeCount <= envelopeCount - 3'd1;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            timerCount <= '0;
            lfsr       <= LfsrSeed;
        end else if (trigger) begin
            timerCount <= period;
            lfsr       <= LfsrSeed;
        end else if (timerActive) begin
            // NR43 changes are picked up here, at reload, never mid-count.
            if (timerCount <= TimerWidth'(1)) begin
                timerCount <= period;
                lfsr       <= lfsrShift(lfsr, nr43[3]);
            end else begin
                timerCount <= timerCount - TimerWidth'(1);
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state    <= StIdle;
            oEnabled <= 1'b0;
            oSample  <= '0;
        end else begin
            oSample <= ((state == StRun) && !lfsr[0]) ? volume : 4'd0;
            unique case (state)
                StIdle: begin
                    if (trigger && dacOn) begin
                        state    <= StRun;
                        oEnabled <= 1'b1;
                    end
                end
                StRun: begin
                    if (dacOffWrite || lengthExpire) begin
                        state    <= StIdle;
                        oEnabled <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noise_channel_controller.sv
// Bench for noise_channel_controller: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against an integer-level channel model.
module tb_noise_channel_controller;

    localparam int FD = 16;

    logic       clk;
    logic       rst;
    logic       we;
    logic [1:0] addr;
    logic [7:0] data;
    logic [3:0] oSample;
    logic       oEnabled;

    int errors = 0;
    int checks = 0;

    noise_channel_controller #(
        .FRAME_DIV(FD)
    ) dut (
        .iClock      (clk),
        .iReset      (rst),
        .iWriteEnable(we),
        .iAddress    (addr),
        .iData       (data),
        .oSample     (oSample),
        .oEnabled    (oEnabled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state, as plain integers.
    int mRun, mNr42, mNr43, mLenEn, mLen, mVol, mEnv, mTimer, mLfsr, mFrame, mSample;
    int mValid = 0;

    function automatic int periodOf(input int nr43);
        int r, s, d;
        r = nr43 & 7;
        s = (nr43 >> 4) & 15;
        d = (r == 0) ? 8 : 16 * r;
        return (d << s) & 'hFFFFF;
    endfunction

    task automatic modelStep(input logic r, input logic w, input logic [1:0] a,
                             input logic [7:0] dIn);
        int d, tick, step, lenTick, envTick, trig, expire, fb;
        d = int'(dIn);
        if (r) begin
            mRun = 0; mNr42 = 0; mNr43 = 0; mLenEn = 0; mLen = 0; mVol = 0; mEnv = 0;
            mTimer = 0; mLfsr = 'h7FFF; mFrame = 0; mSample = 0; mValid = 1;
            return;
        end
        tick    = ((mFrame % FD) == FD - 1);
        step    = (mFrame / FD) % 8;
        lenTick = tick && (step % 2 == 0);
        envTick = tick && (step == 7);
        trig    = w && (a == 3) && (d >= 128);
        mSample = (mRun != 0 && (mLfsr % 2) == 0) ? mVol : 0;
        expire  = lenTick && mLenEn != 0 && mLen == 1 && !trig && !(w && a == 0);
        if (trig) begin
            mTimer = periodOf(mNr43);
            mLfsr  = 'h7FFF;
        end else if (mRun != 0 && ((mNr43 >> 4) < 14)) begin
            if (mTimer <= 1) begin
                fb    = (mLfsr ^ (mLfsr >> 1)) & 1;
                mLfsr = (mLfsr >> 1) | (fb << 14);
                if ((mNr43 & 8) != 0) mLfsr = (mLfsr & ~64) | (fb << 6);
                mTimer = periodOf(mNr43);
            end else begin
                mTimer = mTimer - 1;
            end
        end
        if (trig) begin
            mVol = mNr42 >> 4;
            mEnv = mNr42 & 7;
        end else if (envTick && (mNr42 & 7) != 0) begin
            if (mEnv <= 1) begin
                mEnv = mNr42 & 7;
                if ((mNr42 & 8) != 0) mVol = (mVol < 15) ? mVol + 1 : 15;
                else mVol = (mVol > 0) ? mVol - 1 : 0;
            end else begin
                mEnv = mEnv - 1;
            end
        end
        if (w && a == 0) mLen = 64 - (d & 63);
        else if (trig) begin
            if (mLen == 0) mLen = 64;
        end else if (lenTick && mLenEn != 0 && mLen > 0) mLen = mLen - 1;
        if (trig) mRun = ((mNr42 >> 3) != 0) ? 1 : 0;
        else if (w && a == 1 && (d >> 3) == 0) mRun = 0;
        else if (expire) mRun = 0;
        if (w && a == 1) mNr42 = d;
        if (w && a == 2) mNr43 = d;
        if (w && a == 3) mLenEn = (d >> 6) & 1;
        mFrame = mFrame + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, then advance the model with the inputs the next edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (mValid != 0) begin
                check("sample", 32'(oSample), 32'(mSample));
                check("enabled", 32'(oEnabled), 32'(mRun));
                check("lfsr", 32'(dut.lfsr), 32'(mLfsr));
                check("volume", 32'(dut.volume), 32'(mVol));
            end
            modelStep(rst, we, addr, data);
        end
    end

    task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; data = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; addr = 2'd0; data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("resetEnabled", 32'(oEnabled), 32'd0);
        check("resetSample", 32'(oSample), 32'd0);
        check("resetLfsr", 32'(dut.lfsr), 32'h7FFF);

        // Full-width noise, P = 8.
        writeReg(2'd1, 8'hF0);
        writeReg(2'd2, 8'h00);
        writeReg(2'd3, 8'h80);
        check("trigEnabled", 32'(oEnabled), 32'd1);
        waitCycles(8);
        check("firstShift", 32'(dut.lfsr), 32'h3FFF);
        check("modelFirstShift", 32'(mLfsr), 32'h3FFF);
        waitCycles(112);
        check("sampleBefore15", 32'(oSample), 32'd0);
        waitCycles(1);
        check("sampleAfter15", 32'(oSample), 32'd15);
        check("modelSample15", 32'(mSample), 32'd15);

        // Width mode.
        writeReg(2'd2, 8'h08);
        writeReg(2'd3, 8'h80);
        waitCycles(8);
        check("narrowShift", 32'(dut.lfsr), 32'h3FBF);
        check("modelNarrowShift", 32'(mLfsr), 32'h3FBF);

        // Length expiry on the first length step (tick sampled 16 edges after reset).
        pulseReset();
        writeReg(2'd0, 8'h3F);
        writeReg(2'd1, 8'hF0);
        writeReg(2'd3, 8'hC0);
        check("lenEnabled", 32'(oEnabled), 32'd1);
        waitCycles(12);
        check("lenBeforeTick", 32'(oEnabled), 32'd1);
        waitCycles(1);
        check("lenExpired", 32'(oEnabled), 32'd0);
        check("modelLenExpired", 32'(mRun), 32'd0);
        waitCycles(2);
        check("lenSampleZero", 32'(oSample), 32'd0);

        // Envelope down with period 1: step-7 ticks every 128 cycles.
        pulseReset();
        writeReg(2'd1, 8'hF1);
        writeReg(2'd3, 8'h80);
        waitCycles(125);
        check("envHold15", 32'(dut.volume), 32'd15);
        waitCycles(1);
        check("envFirst14", 32'(dut.volume), 32'd14);
        check("modelEnv14", 32'(mVol), 32'd14);
        waitCycles(128);
        check("envSecond13", 32'(dut.volume), 32'd13);
        waitCycles(128 * 14);
        check("envFloor0", 32'(dut.volume), 32'd0);
        check("modelEnvFloor", 32'(mVol), 32'd0);

        // DAC off while running, then a trigger with the DAC still off.
        writeReg(2'd1, 8'h00);
        check("dacOffEnabled", 32'(oEnabled), 32'd0);
        writeReg(2'd3, 8'h80);
        check("dacOffTrig", 32'(oEnabled), 32'd0);
        waitCycles(5);
        check("dacOffStays", 32'(oEnabled), 32'd0);

        // Shift of 14: the LFSR is never clocked.
        writeReg(2'd1, 8'hF0);
        writeReg(2'd2, 8'hE0);
        writeReg(2'd3, 8'h80);
        waitCycles(300);
        check("bigShiftLfsr", 32'(dut.lfsr), 32'h7FFF);
        check("bigShiftSample", 32'(oSample), 32'd0);
        check("bigShiftEnabled", 32'(oEnabled), 32'd1);

        // Reset in the middle of a run, then a fresh trigger.
        writeReg(2'd2, 8'h00);
        writeReg(2'd3, 8'h80);
        waitCycles(50);
        pulseReset();
        check("midResetEnabled", 32'(oEnabled), 32'd0);
        check("midResetSample", 32'(oSample), 32'd0);
        check("midResetLfsr", 32'(dut.lfsr), 32'h7FFF);
        writeReg(2'd1, 8'hF0);
        writeReg(2'd3, 8'h80);
        check("retrigEnabled", 32'(oEnabled), 32'd1);
        waitCycles(120);
        check("retrigBefore15", 32'(oSample), 32'd0);
        waitCycles(1);
        check("retrigAfter15", 32'(oSample), 32'd15);

        // Randomized traffic, checked by the per-cycle compare.
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 699) == 0);
            we   = ($urandom_range(0, 5) == 0);
            addr = 2'($urandom_range(0, 3));
            data = 8'($urandom);
            if (addr == 2'd2) data[7:4] = 4'($urandom_range(0, 3));
            if (addr == 2'd1 && $urandom_range(0, 3) == 0) data[7:3] = 5'd0;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        we  = 1'b0;
        waitCycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noise_channel_controller.md
# noise_channel_controller

Register-programmable controller that sequences the channel-4 white-noise datapath of the sound subsystem. It decodes the NR41–NR44 register writes and owns the frequency timer that clocks a 15/7-bit LFSR, plus the length counter and volume envelope. It produces the 4-bit channel-4 sample and an enable flag for the sound mixer. It replaces the fixed-rate, free-running noise generator with a triggerable, software-controlled one.

## Interface
Parameters:
- FRAME_DIV, 8192: iClock cycles per frame-sequencer tick (8192 gives 512 Hz at 4.194304 MHz).

Ports:
- iClock  in  1  system clock
- iReset  in  1  reset; synchronous, active-high (already decided)
- iWriteEnable  in  1  one-cycle register write strobe
- iAddress  in  2  register select: 0=NR41, 1=NR42, 2=NR43, 3=NR44
- iData  in  8  write data
- oSample  out  4  current channel output level
- oEnabled  out  1  channel active flag

## Operation
- Register fields:
  - NR41[5:0] is the length load t; a write sets the length counter to 64−t.
  - NR42[7:4] is the initial volume; NR42[3] is the envelope direction (1 = up); NR42[2:0] is the envelope period.
  - NR43[7:4] is the shift s; NR43[3] is the width mode (1 = 7-bit); NR43[2:0] is the divisor code r.
  - NR44[7] is trigger (write-only, self-clearing); NR44[6] is length enable.
- Timer period: P = D(r) << s, where D(0)=8 and D(r)=16·r otherwise. P is at most 20 bits.
  - When s ≥ 14, the LFSR is never clocked.
- Frequency timer:
  - Loaded with P on trigger.
  - Each cycle while enabled: if the count is 1, shift the LFSR and reload P; otherwise decrement.
- LFSR shift: x = lfsr[0] ^ lfsr[1]; lfsr = {x, lfsr[14:1]}. In width mode, bit 6 is also overwritten with x.
- Frame sequencer:
  - A tick occurs every FRAME_DIV cycles; a 3-bit step counter advances on each tick.
  - Length is clocked on steps 0, 2, 4 and 6; the envelope is clocked on step 7.
  - The sequencer runs regardless of the enable state.
- Length counter: if length enable is set and the count is > 0, decrement. On reaching 0, clear oEnabled.
- Envelope:
  - Period 0 means the volume is frozen.
  - Otherwise a down-counter reloads to the period on each expiry; at each expiry the volume steps ±1, saturating at 0 and 15.
- States:
  - IDLE: oEnabled=0 and the timer is frozen.
  - RUN: entered on trigger when the DAC is on (NR42[7:3] ≠ 0).
  - RUN → IDLE when length expires or when NR42 is written with [7:3]=0.
- Trigger actions:
  - Length 0 → reload 64.
  - Timer is loaded with P.
  - LFSR is set to 0x7FFF.
  - Volume is set to NR42[7:4]; the envelope counter is set to the envelope period.
  - A trigger with the DAC off leaves the block in IDLE.
- Output: oSample = volume when in RUN and lfsr[0]=0; otherwise 0.
- NR43 writes take effect at the next reload; the running count is not disturbed.

## Timing
- All outputs are registered.
- oSample reflects the LFSR/volume state one cycle after it changes.
- oEnabled rises on the cycle after the trigger write.
- First LFSR shift occurs P cycles after the trigger write.
- Reset values:
  - oSample=0, oEnabled=0, all registers 0.
  - LFSR 0x7FFF, step counter 0, frame counter 0, state IDLE.
- Simultaneous events:
  - Trigger and length tick in the same cycle: the trigger wins and the tick is dropped for length.
  - NR41 write and length tick in the same cycle: the write wins.
  - DAC-off write and trigger cannot coincide (single write port).
- Reset mid-operation restores all reset values in the next cycle; no partial state survives.

## Structure
- Shared package `sound_pkg`:
  - register address constants
  - divisor lookup function D(r)
  - LFSR width and seed (0x7FFF)
  - frame step constants for length and envelope
- Sub-module `sound_frame_sequencer` (FRAME_DIV counter plus 3-bit step, emitting length/envelope tick pulses). It is natural to share with channels 1–3.

## Test plan
- DAC/width check: NR42=0xF0, NR43=0x00, NR44=0x80 →
  - oEnabled=1 after 1 cycle.
  - LFSR shifts every 8 cycles.
  - oSample=0 for the first 14 shifts.
  - oSample=15 after the 15th shift (cycle 121).
  - Repeat with NR43=0x08: the first shift yields LFSR=0x3FBF.
- Length expiry: FRAME_DIV=16, NR41=0x3F, NR42=0xF0, NR44=0xC0 → oEnabled falls on the first length step; oSample=0 thereafter.
- Envelope: NR42=0xF1, trigger → volume goes 15→14 at the first step-7 tick, then decrements each subsequent step-7 tick and holds at 0.
- DAC off: NR42=0x00 written while running → oEnabled=0 next cycle. A following NR44=0x80 keeps oEnabled=0.
- Large shift: NR43=0xE0, trigger → LFSR stays 0x7FFF indefinitely and oSample stays 0.
- Reset mid-run: assert iReset during RUN → next cycle oEnabled=0, oSample=0, LFSR=0x7FFF; a re-trigger behaves as in the first test.
